opc_bus_ctrl: RTL and testbench

Parametrised bus controller for OPC-family CPU systems on iCE40 boards. It replaces the hard-coded RAM/UART decode, fixed read-data mux and single-flop reset of the current system top. It provides N decoded peripheral channels with per-channel wait states and ready handshake, plus a bus timeout with error capture. It also sequences CPU reset from PLL lock, and sits between the CPU and all memory-mapped slaves.

---
 rtl/opc_bus_pkg.sv | 12 +
 rtl/opc_reset_seq.sv | 36 +++
 rtl/opc_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_opc_bus_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/opc_bus_pkg.sv
// opc_bus_pkg: shared state encodings, counter widths and packed-field helper for the OPC bus controller
package opc_bus_pkg;
  typedef enum logic {HOLD, RUN} rst_state_e;
  typedef enum logic {IDLE, STALL} acc_state_e;
  localparam int RST_CW = 10;
  localparam int WAIT_W = 4;
  localparam int TO_W = 8;
  localparam logic [15:0] DEF_DATA = 16'hffff;
  function automatic logic [31:0] field(input logic [255:0] vec, input int idx, input int w);
    return 32'((vec >> (idx * w)) & ((256'(1) << w) - 256'(1)));
  endfunction
endpackage

// File: rtl/opc_reset_seq.sv
// opc_reset_seq: holds reset until pll_lock_i has been high for RST_STRETCH consecutive cycles
// Ports: clk, rst (sync, active high), pll_lock_i, run_o (registered, high once released)
module opc_reset_seq
  import opc_bus_pkg::*;
#(
  parameter int RST_STRETCH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock_i,
  output logic run_o
);
  rst_state_e state_q, state_d;
  logic [RST_CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!pll_lock_i) begin
      state_d = HOLD;
      cnt_d = '0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == RST_CW'(RST_STRETCH - 1) ? RUN : HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign run_o = state_q == RUN;
endmodule

// File: rtl/opc_bus_ctrl.sv
// opc_bus_ctrl: N-channel address decoder with wait states, ack handshake, bus timeout and CPU reset sequencing
// Ports: clk/reset/pll_lock; cpu_* CPU side; chan_* slave side; bus_err/err_addr report timed-out accesses
module opc_bus_ctrl
  import opc_bus_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int NCHAN = 4,
  parameter logic [NCHAN*AW-1:0] BASE = '0,
  parameter logic [NCHAN*AW-1:0] MASK = '1,
  parameter logic [NCHAN*WAIT_W-1:0] WAIT = '0,
  parameter int TIMEOUT = 15,
  parameter int RST_STRETCH = 16,
  parameter logic [DW-1:0] DEFAULT_DATA = DW'(DEF_DATA)
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic [AW-1:0] cpu_address,
  input  logic cpu_rnw,
  input  logic cpu_vda,
  output logic [DW-1:0] cpu_din,
  output logic cpu_clken,
  output logic cpu_reset_b,
  output logic [NCHAN-1:0] chan_cs_b,
  output logic chan_rnw,
  input  logic [NCHAN*DW-1:0] chan_dout,
  input  logic [NCHAN-1:0] chan_ack,
  output logic bus_err,
  output logic [AW-1:0] err_addr
);
  localparam int IW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  logic [AW-1:0] base_a [NCHAN];
  logic [AW-1:0] mask_a [NCHAN];
  logic [WAIT_W-1:0] wait_a [NCHAN];
  logic [DW-1:0] dout_a [NCHAN];
  logic [NCHAN-1:0] hit;
  logic any_hit, run, acc, done, tmo, err_d;
  logic [IW-1:0] idx, ch_q, ch_d;
  acc_state_e state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] eaddr_d;
  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    assign base_a[i] = AW'(field(256'(BASE), i, AW));
    assign mask_a[i] = AW'(field(256'(MASK), i, AW));
    assign wait_a[i] = WAIT_W'(field(256'(WAIT), i, WAIT_W));
    assign dout_a[i] = chan_dout[i*DW +: DW];
    assign hit[i] = (cpu_address & mask_a[i]) == (base_a[i] & mask_a[i]);
  end
  opc_reset_seq #(.RST_STRETCH(RST_STRETCH)) u_rst (
    .clk(clk),
    .rst(reset),
    .pll_lock_i(pll_lock),
    .run_o(run)
  );
  assign cpu_reset_b = run;
  assign chan_rnw = cpu_rnw;
  assign acc = run && cpu_vda;
  assign done = wcnt_q == '0 && chan_ack[ch_q];
  assign tmo = tcnt_q == TO_W'(TIMEOUT - 1);
  always_comb begin
    any_hit = 1'b0;
    idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        idx = IW'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    ch_d = ch_q;
    chan_cs_b = '1;
    cpu_clken = 1'b1;
    cpu_din = DEFAULT_DATA;
    err_d = 1'b0;
    eaddr_d = err_addr;
    if (state_q == IDLE) begin
      if (acc && any_hit) begin
        chan_cs_b[idx] = 1'b0;
        cpu_din = dout_a[idx];
        if (wait_a[idx] != '0 || !chan_ack[idx]) begin
          // The IDLE cycle is itself the first stall, so one fewer remains
          cpu_clken = 1'b0;
          state_d = STALL;
          wcnt_d = wait_a[idx] == '0 ? '0 : wait_a[idx] - 1'b1;
          tcnt_d = '0;
          ch_d = idx;
        end
      end
    end else begin
      chan_cs_b[ch_q] = 1'b0;
      wcnt_d = wcnt_q == '0 ? '0 : wcnt_q - 1'b1;
      tcnt_d = tcnt_q + 1'b1;
      cpu_clken = done || tmo;
      cpu_din = done ? dout_a[ch_q] : DEFAULT_DATA;
      state_d = done || tmo ? IDLE : STALL;
      err_d = tmo && !done && pll_lock;
      eaddr_d = err_d ? cpu_address : err_addr;
      if (!pll_lock) state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      tcnt_q <= '0;
      ch_q <= '0;
      bus_err <= 1'b0;
      err_addr <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
      ch_q <= ch_d;
      bus_err <= err_d;
      err_addr <= eaddr_d;
    end
  end
endmodule

// File: tb/tb_opc_bus_ctrl.sv
// tb_opc_bus_ctrl: directed scoreboard bench for opc_bus_ctrl
module tb_opc_bus_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_lock = 1'b1;
  logic [15:0] cpu_address = '0;
  logic cpu_rnw = 1'b1;
  logic cpu_vda = 1'b0;
  logic [15:0] cpu_din;
  logic cpu_clken, cpu_reset_b, chan_rnw, bus_err;
  logic [3:0] chan_cs_b;
  logic [63:0] chan_dout = {16'hd333, 16'hc222, 16'hb111, 16'ha000};
  logic [3:0] chan_ack = 4'hf;
  logic [15:0] err_addr;
  logic [15:0] sb_q [$];
  int vecs = 0;
  int errs = 0;
  opc_bus_ctrl #(
    .BASE({16'h0000, 16'h4000, 16'hfe08, 16'h0000}),
    .MASK({16'hff00, 16'hffff, 16'hfffe, 16'hffff}),
    .WAIT({4'd0, 4'd3, 4'd0, 4'd0}),
    .TIMEOUT(15),
    .RST_STRETCH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .cpu_address(cpu_address),
    .cpu_rnw(cpu_rnw),
    .cpu_vda(cpu_vda),
    .cpu_din(cpu_din),
    .cpu_clken(cpu_clken),
    .cpu_reset_b(cpu_reset_b),
    .chan_cs_b(chan_cs_b),
    .chan_rnw(chan_rnw),
    .chan_dout(chan_dout),
    .chan_ack(chan_ack),
    .bus_err(bus_err),
    .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic release_count(input bit drop, output int n);
    n = 0;
    while (!cpu_reset_b && n < 64) begin
      @(posedge clk);
      n++;
      #1;
      if (drop && n == 7) pll_lock = 1'b0;
      if (drop && n == 8) pll_lock = 1'b1;
    end
  endtask
  task automatic access(input string tag, input logic [15:0] a, input logic rnw, input logic [15:0] exp_d,
                        input int exp_st, input logic [3:0] exp_cs);
    int st;
    @(posedge clk);
    #1;
    cpu_address = a;
    cpu_rnw = rnw;
    cpu_vda = 1'b1;
    sb_q.push_back(exp_d);
    @(negedge clk);
    chk({tag, "_cs"}, 32'(chan_cs_b), 32'(exp_cs));
    chk({tag, "_rnw"}, 32'(chan_rnw), 32'(rnw));
    st = 0;
    while (!cpu_clken && st < 40) begin
      st++;
      @(negedge clk);
    end
    chk({tag, "_stalls"}, 32'(st), 32'(exp_st));
    chk({tag, "_din"}, 32'(cpu_din), 32'(sb_q.pop_front()));
    @(posedge clk);
    #1;
    cpu_vda = 1'b0;
  endtask
  initial begin
    int n, seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reset_b", 32'(cpu_reset_b), 32'(0));
    chk("rst_clken", 32'(cpu_clken), 32'(1));
    chk("rst_cs", 32'(chan_cs_b), 32'(4'hf));
    chk("rst_bus_err", 32'(bus_err), 32'(0));
    chk("rst_err_addr", 32'(err_addr), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    release_count(1'b0, n);
    chk("release_cycles", 32'(n), 32'(16));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rereset_reset_b", 32'(cpu_reset_b), 32'(0));
    reset = 1'b0;
    release_count(1'b1, n);
    chk("release_drop_cycles", 32'(n), 32'(24));
    access("zw_read", 16'hfe09, 1'b1, 16'hb111, 0, 4'b1101);
    access("wait_read", 16'h4000, 1'b1, 16'hc222, 3, 4'b1011);
    access("overlap", 16'h0000, 1'b1, 16'ha000, 0, 4'b1110);
    access("ch3_read", 16'h0010, 1'b1, 16'hd333, 0, 4'b0111);
    access("unmapped", 16'h8000, 1'b1, 16'hffff, 0, 4'b1111);
    access("wait_write", 16'h4000, 1'b0, 16'hc222, 3, 4'b1011);
    chan_ack = 4'b1011;
    access("timeout", 16'h4000, 1'b1, 16'hffff, 15, 4'b1011);
    @(negedge clk);
    chk("to_bus_err", 32'(bus_err), 32'(1));
    chk("to_err_addr", 32'(err_addr), 32'(16'h4000));
    @(negedge clk);
    chk("to_bus_err_pulse", 32'(bus_err), 32'(0));
    @(posedge clk);
    #1;
    cpu_address = 16'h4000;
    cpu_rnw = 1'b1;
    cpu_vda = 1'b1;
    @(negedge clk);
    chk("ll_clken", 32'(cpu_clken), 32'(0));
    @(negedge clk);
    chk("ll_cs_stall", 32'(chan_cs_b), 32'(4'b1011));
    @(posedge clk);
    #1;
    pll_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ll_reset_b", 32'(cpu_reset_b), 32'(0));
    chk("ll_cs", 32'(chan_cs_b), 32'(4'hf));
    chk("ll_bus_err", 32'(bus_err), 32'(0));
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_err) seen++;
    end
    chk("ll_no_err", 32'(seen), 32'(0));
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
